// File: rtl/sum_tx_sequencer_if.sv
// Signal bundle between the sum/transmit sequencer and its surroundings:
// operand capture inputs, UART handshake and the visible operand/sum state.
interface sum_tx_sequencer_if #(
  parameter int DATA_W = 4
);
  logic              save_a_n;
  logic              save_b_n;
  logic [DATA_W-1:0] data_input;
  // UART handshake: tx_start is a one-cycle request for tx_data; the UART
  // acknowledges by raising tx_busy and reports completion by dropping it.
  // A request is only issued while tx_busy is low, and tx_data is held
  // from tx_start until the next tx_start.
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W:0]   sum_val;
  logic              seq_busy;
  logic              overrun;

  modport master (
    input  save_a_n, save_b_n, data_input, tx_busy,
    output tx_start, tx_data, a_val, b_val, sum_val, seq_busy, overrun
  );

  modport slave (
    output save_a_n, save_b_n, data_input, tx_busy,
    input  tx_start, tx_data, a_val, b_val, sum_val, seq_busy, overrun
  );
endinterface

// File: rtl/sum_tx_sequencer.sv
// Captures operands A/B from debounced-free async strobes, adds them and sends
// the sum to a UART as tens digit, ones digit and an end-of-line byte.
module sum_tx_sequencer #(
  parameter int         DATA_W      = 4,
  parameter logic [7:0] EOL_BYTE    = 8'h0D,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  sum_tx_sequencer_if.master         bus,
  output logic [2:0]                 dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_ACK  = 3'd2,
    ST_DONE = 3'd3,
    ST_NEXT = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  // [0],[1] synchronize; [2] is the previous synchronized value for edge detect.
  logic [2:0]        a_sync_q, b_sync_q;
  logic              a_ev_q, b_ev_q;
  logic              a_ev_d, b_ev_d;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W:0]   sum_q, sum_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [7:0]        byte1_q, byte1_d;
  logic              overrun_q, overrun_d;

  logic [DATA_W-1:0] a_op;
  logic [DATA_W:0]   sum_new;
  logic [4:0]        sum_ext;
  logic [1:0]        tens;
  logic [4:0]        ones;

  assign a_ev_d = a_sync_q[2] & ~a_sync_q[1];
  assign b_ev_d = b_sync_q[2] & ~b_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync_q <= 3'b111;
      b_sync_q <= 3'b111;
      a_ev_q   <= 1'b0;
      b_ev_q   <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[1:0], bus.save_a_n};
      b_sync_q <= {b_sync_q[1:0], bus.save_b_n};
      a_ev_q   <= a_ev_d;
      b_ev_q   <= b_ev_d;
    end
  end

  // A simultaneous A event must feed the sum so that A and B both take data_input.
  always_comb begin
    a_op    = a_ev_q ? bus.data_input : a_q;
    sum_new = {1'b0, a_op} + {1'b0, bus.data_input};
    sum_ext = 5'(sum_new);
    tens    = 2'd0;
    ones    = sum_ext;
    if (sum_ext >= 5'd30) begin
      tens = 2'd3;
      ones = sum_ext - 5'd30;
    end else if (sum_ext >= 5'd20) begin
      tens = 2'd2;
      ones = sum_ext - 5'd20;
    end else if (sum_ext >= 5'd10) begin
      tens = 2'd1;
      ones = sum_ext - 5'd10;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    overrun_d  = overrun_q;

    if (a_ev_q) a_d = bus.data_input;
    if (b_ev_q && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (b_ev_q) begin
          b_d     = bus.data_input;
          sum_d   = sum_new;
          byte0_d = 8'h30 + {6'd0, tens};
          byte1_d = 8'h30 + {3'd0, ones};
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = (idx_q == 2'd0) ? byte0_q :
                       (idx_q == 2'd1) ? byte1_q : EOL_BYTE;
          cnt_d      = '0;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        // A UART that never acknowledges costs the byte, not the whole message.
        if (bus.tx_busy)            state_d = ST_DONE;
        else if (cnt_q == CNT_LAST) state_d = ST_NEXT;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (!bus.tx_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == 2'd2) begin
          idx_d   = 2'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      byte0_q    <= 8'h00;
      byte1_q    <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.a_val    = a_q;
  assign bus.b_val    = b_q;
  assign bus.sum_val  = sum_q;
  assign bus.seq_busy = (state_q != ST_IDLE);
  assign bus.overrun  = overrun_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed + randomized bench for sum_tx_sequencer with a simple UART model
// and a byte scoreboard built from the decimal-digit message rule.
module tb_sum_tx_sequencer;
  localparam int         DATA_W      = 4;
  localparam int         ACK_TIMEOUT = 16;
  localparam logic [7:0] EOL         = 8'h0D;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  sum_tx_sequencer_if #(.DATA_W(DATA_W)) bus ();

  sum_tx_sequencer #(
    .DATA_W(DATA_W), .EOL_BYTE(EOL), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int start_cyc_q[$];
  int start_cnt = 0;
  int data_viol = 0;
  int cyc = 0;
  bit uart_en = 1'b1;
  bit pend = 1'b0;
  int bcnt = 0;
  logic [7:0] held = 8'h00;

  // UART model: busy rises one cycle after a start and stays high 10 cycles.
  always @(negedge clk) begin
    cyc++;
    if (reset !== 1'b0) begin
      bus.tx_busy = 1'b0;
      pend = 1'b0;
      bcnt = 0;
    end else begin
      if (bus.tx_busy) begin
        if (bus.tx_data !== held) data_viol++;
        bcnt--;
        if (bcnt == 0) bus.tx_busy = 1'b0;
      end else if (pend) begin
        bus.tx_busy = 1'b1;
        bcnt = 10;
        pend = 1'b0;
      end
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        got_q.push_back(bus.tx_data);
        start_cyc_q.push_back(cyc);
        held = bus.tx_data;
        if (uart_en) pend = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_msg(input int s);
    exp_q.push_back(8'(8'h30 + s / 10));
    exp_q.push_back(8'(8'h30 + s % 10));
    exp_q.push_back(EOL);
  endfunction

  task automatic press(input bit do_a, input bit do_b, input logic [3:0] v);
    @(negedge clk);
    bus.data_input = v;
    if (do_a) bus.save_a_n = 1'b0;
    if (do_b) bus.save_b_n = 1'b0;
    repeat (4) @(negedge clk);
    bus.save_a_n = 1'b1;
    bus.save_b_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.seq_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < 3000), 1);
    chk({tag, "_uart_idle_at_end"}, 32'(bus.tx_busy), 0);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_byte_count"}, got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0)
        chk($sformatf("%s_byte%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // B capture with A already loaded; checks the full resulting message.
  task automatic send_b(input string tag, input int a, input int b);
    int base;
    base = start_cnt;
    got_q.delete();
    exp_q.delete();
    push_msg(a + b);
    press(1'b0, 1'b1, 4'(b));
    wait_done(tag);
    chk({tag, "_sum"}, bus.sum_val, a + b);
    chk({tag, "_b_val"}, bus.b_val, b);
    chk({tag, "_starts"}, start_cnt - base, 3);
    check_bytes(tag);
  endtask

  task automatic run_msg(input string tag, input int a, input int b);
    press(1'b1, 1'b0, 4'(a));
    chk({tag, "_a_val"}, bus.a_val, a);
    send_b(tag, a, b);
  endtask

  initial begin
    int base;
    int n;
    int k;
    int d;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.save_a_n = 1'b1;
    bus.save_b_n = 1'b1;
    bus.data_input = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_a_val", bus.a_val, 0);
    chk("rst_b_val", bus.b_val, 0);
    chk("rst_sum_val", bus.sum_val, 0);
    chk("rst_seq_busy", bus.seq_busy, 0);
    chk("rst_overrun", bus.overrun, 0);

    repeat (20) @(negedge clk);
    chk("idle_no_start", start_cnt, 0);
    chk("idle_seq_busy", bus.seq_busy, 0);
    chk("idle_sum_val", bus.sum_val, 0);

    // Capture latency: strobe falls before edge N, A loads at edge N+3.
    @(negedge clk);
    bus.data_input = 4'd7;
    bus.save_a_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("a_latency_early", bus.a_val, 0);
    @(posedge clk);
    #1 chk("a_latency", bus.a_val, 7);
    @(negedge clk);
    bus.data_input = 4'd3;
    repeat (5) @(negedge clk);
    chk("a_held_no_repeat", bus.a_val, 7);
    bus.save_a_n = 1'b1;
    bus.data_input = 4'd7;
    repeat (4) @(negedge clk);
    chk("a_no_sum_update", bus.sum_val, 0);

    send_b("m7_9", 7, 9);
    run_msg("m15_15", 15, 15);
    run_msg("m2_3", 2, 3);

    d = $urandom_range(0, 15);
    base = start_cnt;
    got_q.delete();
    exp_q.delete();
    push_msg(2 * d);
    press(1'b1, 1'b1, 4'(d));
    wait_done("simul");
    chk("simul_a", bus.a_val, d);
    chk("simul_b", bus.b_val, d);
    chk("simul_sum", bus.sum_val, 2 * d);
    chk("simul_starts", start_cnt - base, 3);
    check_bytes("simul");

    for (int i = 0; i < 4; i++)
      run_msg($sformatf("rnd%0d", i), $urandom_range(0, 15), $urandom_range(0, 15));

    // Rejected B and accepted A while a message is in flight.
    press(1'b1, 1'b0, 4'd5);
    base = start_cnt;
    got_q.delete();
    exp_q.delete();
    push_msg(11);
    press(1'b0, 1'b1, 4'd6);
    n = 0;
    while ((start_cnt - base) < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_reach_byte1", 32'(n < 500), 1);
    press(1'b0, 1'b1, 4'd4);
    press(1'b1, 1'b0, 4'd12);
    wait_done("ovr");
    chk("ovr_b_val", bus.b_val, 6);
    chk("ovr_sum", bus.sum_val, 11);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_a_val", bus.a_val, 12);
    chk("ovr_starts", start_cnt - base, 3);
    check_bytes("ovr");

    // Silent UART: each byte is abandoned after the ACK timeout.
    uart_en = 1'b0;
    press(1'b1, 1'b0, 4'd4);
    base = start_cnt;
    k = start_cyc_q.size();
    got_q.delete();
    exp_q.delete();
    push_msg(12);
    press(1'b0, 1'b1, 4'd8);
    wait_done("tmo");
    chk("tmo_starts", start_cnt - base, 3);
    if (start_cyc_q.size() >= k + 3) begin
      // timeout cycles in ACK, then one NEXT and one SEND cycle
      chk("tmo_gap0", start_cyc_q[k+1] - start_cyc_q[k], ACK_TIMEOUT + 2);
      chk("tmo_gap1", start_cyc_q[k+2] - start_cyc_q[k+1], ACK_TIMEOUT + 2);
    end
    check_bytes("tmo");
    uart_en = 1'b1;

    // Reset while byte1 (8'h38 for 9+9) is being requested.
    press(1'b1, 1'b0, 4'd9);
    press(1'b0, 1'b1, 4'd9);
    n = 0;
    while (!(bus.tx_start === 1'b1 && bus.tx_data === 8'h38) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_found_byte1", 32'(n < 500), 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_tx_start", bus.tx_start, 0);
    chk("rstmid_seq_busy", bus.seq_busy, 0);
    chk("rstmid_overrun", bus.overrun, 0);
    chk("rstmid_tx_data", bus.tx_data, 0);
    chk("rstmid_sum", bus.sum_val, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = start_cnt;
    repeat (30) @(negedge clk);
    chk("rstmid_no_resume", start_cnt - base, 0);
    chk("rstmid_idle", bus.seq_busy, 0);
    run_msg("post_rst", $urandom_range(0, 15), $urandom_range(0, 15));

    chk("tx_data_stable", data_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_tx_sequencer.md
# sum_tx_sequencer

Control block between the operand-capture inputs and the UART transmitter of the sum-latch system. It synchronizes the active-low save strobes, captures operand A and operand B from the shared 4-bit data input, and computes their sum. It then schedules the UART as a three-byte message: tens digit (ASCII), ones digit (ASCII), end-of-line byte. It owns the UART start/busy handshake and rejects new B captures while a message is in flight.

## Interface

Parameters:
- DATA_W, 4, operand width; legal range 1..4, so the sum never exceeds 30 and two decimal digits always suffice.
- EOL_BYTE, 8'h0D, third byte of every message.
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before abandoning that byte.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- save_a_n  in  1  asynchronous, active-low capture strobe for operand A.
- save_b_n  in  1  asynchronous, active-low capture strobe for operand B; triggers a transmission.
- data_input  in  DATA_W  operand value; sampled at the capture cycle.
- tx_busy  in  1  UART busy flag; high while a byte is shifting out.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  8  byte presented to the UART; stable from tx_start until the byte completes.
- a_val  out  DATA_W  captured operand A.
- b_val  out  DATA_W  captured operand B.
- sum_val  out  DATA_W+1  a_val + b_val, computed at the B capture.
- seq_busy  out  1  high from the B capture until the last byte completes.
- overrun  out  1  sticky; set when a B capture is rejected.

## Operation

- Each strobe passes through a 2-flop synchronizer and then a falling-edge detector. A save event is a single-cycle pulse per press; a held-low strobe does not repeat.
- Save A event: a_val <= data_input. This is accepted in any state. sum_val is not recomputed.
- Save B event with seq_busy low: b_val <= data_input and sum_val <= a_val + data_input (zero-extended, no overflow possible). The block then latches the message bytes and enters SEND.
- Simultaneous A and B events in the same cycle: a_val and b_val both load data_input, and sum_val = 2*data_input.
- Save B event with seq_busy high: b_val and sum_val are unchanged, overrun <= 1, and the event is dropped.
- Message bytes: byte0 = 8'h30 + sum/10, byte1 = 8'h30 + sum%10, byte2 = EOL_BYTE. A leading zero is always sent.
- States:
  - IDLE: waits for an accepted B event, then goes to SEND with idx=0.
  - SEND: waits until tx_busy is low, then pulses tx_start with tx_data = byte[idx] and goes to ACK.
  - ACK: waits for tx_busy high, then goes to DONE. If ACK_TIMEOUT cycles elapse without it, goes to NEXT (byte abandoned, no flag).
  - DONE: waits for tx_busy low, then goes to NEXT.
  - NEXT: if idx==2, goes to IDLE; otherwise idx++ and goes to SEND.
- seq_busy is high in every state except IDLE.

## Timing

- Reset values: tx_start=0, tx_data=8'h00, a_val=0, b_val=0, sum_val=0, seq_busy=0, overrun=0. The FSM is in IDLE with idx=0 and synchronizers cleared to 1 (released).
- Capture latency:
  - The strobe falls before clock edge N.
  - The event pulse is high in cycle N+2.
  - Registers update at edge N+3.
- With tx_busy low, tx_start pulses in the cycle after the SEND entry, i.e. 1 cycle after the B capture updates sum_val.
- Back-to-back bytes: NEXT→SEND→tx_start costs 2 cycles after tx_busy falls.
- tx_data holds its value until the next tx_start; it is never changed while tx_busy is high.
- Reset asserted mid-message:
  - All outputs drop to reset values immediately (asynchronously).
  - The UART byte in progress is not this block's concern.
  - After reset release, no message resumes.

## Test plan

- Reset, then idle 20 cycles -> all outputs 0 and no tx_start pulse.
- A=7 then B=9, with a UART model (busy 1 cycle after start, for 10 cycles) -> sum_val=16; bytes 8'h31, 8'h36, 8'h0D in order; seq_busy falls after the third busy falls.
- A=15, B=15 -> sum_val=30 and bytes 8'h33, 8'h30, 8'h0D. A=2, B=3 -> bytes 8'h30, 8'h35, 8'h0D.
- B pressed again during the second byte, with data=4 -> b_val unchanged, overrun=1, exactly 3 tx_start pulses. A pressed mid-message -> a_val updates and the transmitted bytes are unchanged.
- tx_busy held low permanently -> each byte advances after ACK_TIMEOUT=16 cycles, and the FSM returns to IDLE after 3 tx_start pulses.
- Reset asserted during byte1 -> tx_start, seq_busy and overrun drop to 0 at once. No tx_start after release until a new A/B sequence, which then sends a full 3-byte message.
